// File: rtl/rtc_pkg.sv
// Shared field layout, month constants and helper functions for the
// real-time clock / calendar core.
package rtc_pkg;

  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;
  localparam int DAY_W    = 5;
  localparam int MONTH_W  = 4;

  localparam int TIME_W     = 17;  // {hour, min, sec}
  localparam int OUT_TIME_W = 18;  // {pm, hour, min, sec}

  localparam int SEC_LSB   = 0;
  localparam int MIN_LSB   = 6;
  localparam int HOUR_LSB  = 12;
  localparam int PM_BIT    = 17;

  localparam int DAY_LSB   = 0;
  localparam int MONTH_LSB = 5;
  localparam int YEAR_LSB  = 9;

  localparam logic [MONTH_W-1:0] MONTH_JAN = 4'd1;
  localparam logic [MONTH_W-1:0] MONTH_FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MONTH_MAR = 4'd3;
  localparam logic [MONTH_W-1:0] MONTH_APR = 4'd4;
  localparam logic [MONTH_W-1:0] MONTH_MAY = 4'd5;
  localparam logic [MONTH_W-1:0] MONTH_JUN = 4'd6;
  localparam logic [MONTH_W-1:0] MONTH_JUL = 4'd7;
  localparam logic [MONTH_W-1:0] MONTH_AUG = 4'd8;
  localparam logic [MONTH_W-1:0] MONTH_SEP = 4'd9;
  localparam logic [MONTH_W-1:0] MONTH_OCT = 4'd10;
  localparam logic [MONTH_W-1:0] MONTH_NOV = 4'd11;
  localparam logic [MONTH_W-1:0] MONTH_DEC = 4'd12;

  // Days in a month. Years are 2000-based, so the two low year bits alone
  // decide leap-ness (2000 is a leap year and the range never reaches 2100).
  function automatic logic [DAY_W-1:0] month_len(input logic [MONTH_W-1:0] month,
                                                 input logic [1:0]         year_lo);
    case (month)
      MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: month_len = 5'd30;
      MONTH_FEB: month_len = (year_lo == 2'b00) ? 5'd29 : 5'd28;
      default:   month_len = 5'd31;
    endcase
  endfunction

  // 24h hour to {pm, hour 1..12}: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
  function automatic logic [HOUR_W:0] to_h12(input logic [HOUR_W-1:0] hour);
    logic              pm;
    logic [HOUR_W-1:0] h;
    pm = (hour >= 5'd12);
    h  = pm ? (hour - 5'd12) : hour;
    if (h == 5'd0) h = 5'd12;
    return {pm, h};
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides CLK down to a one-cycle TICK every TICKS_PER_SEC cycles.
// CLR restarts the count so a freshly loaded time gets a full second.
module rtc_prescaler #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic CLR,
  output logic TICK
);

  localparam int CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_p0;

  // Free-running modulo-TICKS_PER_SEC counter, cleared by reset or CLR.
  always_ff @(posedge CLK) begin
    if (!RESETN || CLR) begin
      cnt_p0 <= '0;
    end else if (cnt_p0 == LAST) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  assign TICK = (cnt_p0 == LAST);

endmodule

// File: rtl/rtc_calendar_core.sv
// Real-time clock and calendar: sec/min/hour/day/month/year counters with
// true month lengths and leap Februaries, sanitised loads, 12h/24h output
// mapping and a freezable output snapshot.
// Optional alarm comparator built only when RTC_ALARM_EN is defined.
module rtc_calendar_core
  import rtc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int YEAR_W        = 7,
  parameter int YEAR_INIT     = 16,
  parameter int YEAR_MAX      = 99,
  parameter int H12           = 0
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              SET_EN,
  input  logic [16:0]       SET_TIME,
  input  logic [YEAR_W+8:0] SET_DATE,
  input  logic              HOLD,
  input  logic [16:0]       ALARM_TIME,
  input  logic              ALARM_ARM,
  output logic              SEC_TICK,
  output logic [17:0]       OUT_TIME,
  output logic [YEAR_W+8:0] OUT_DATE,
  output logic              ALARM_HIT
);

  localparam logic [YEAR_W-1:0] YMAX  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] YINIT = YEAR_W'(YEAR_INIT);
  localparam logic [17:0] OUT_TIME_RST = (H12 != 0) ? {1'b0, 5'd12, 12'd0} : 18'd0;

  function automatic logic [5:0] sat_sixty(input logic [5:0] v);
    return (v > 6'd59) ? 6'd0 : v;
  endfunction

  function automatic logic [4:0] sat_hour(input logic [4:0] v);
    return (v > 5'd23) ? 5'd0 : v;
  endfunction

  function automatic logic [3:0] sat_month(input logic [3:0] v);
    return ((v == 4'd0) || (v > MONTH_DEC)) ? MONTH_JAN : v;
  endfunction

  function automatic logic [YEAR_W-1:0] sat_year(input logic [YEAR_W-1:0] v);
    return (v > YMAX) ? YMAX : v;
  endfunction

  function automatic logic [4:0] sat_day(input logic [4:0] v, input logic [4:0] len);
    if (v == 5'd0) return 5'd1;
    return (v > len) ? len : v;
  endfunction

  logic tick;

  logic [5:0]        sec_p0, minute_p0;
  logic [4:0]        hour_p0, day_p0;
  logic [3:0]        month_p0;
  logic [YEAR_W-1:0] year_p0;

  logic [5:0]        sec_nx, minute_nx;
  logic [4:0]        hour_nx, day_nx;
  logic [3:0]        month_nx;
  logic [YEAR_W-1:0] year_nx;
  logic [4:0]        cur_mlen;

  logic [5:0]        set_sec, set_minute;
  logic [4:0]        set_hour, set_day;
  logic [3:0]        set_month;
  logic [YEAR_W-1:0] set_year;

  logic [5:0]        disp_hour;
  logic              sec_tick_p1;

  rtc_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .CLK    (CLK),
    .RESETN (RESETN),
    .CLR    (SET_EN),
    .TICK   (tick)
  );

  // Counter values one second later, including the full carry chain.
  always_comb begin
    sec_nx    = sec_p0;
    minute_nx = minute_p0;
    hour_nx   = hour_p0;
    day_nx    = day_p0;
    month_nx  = month_p0;
    year_nx   = year_p0;
    cur_mlen  = month_len(month_p0, year_p0[1:0]);
    if (sec_p0 != 6'd59) begin
      sec_nx = sec_p0 + 6'd1;
    end else begin
      sec_nx = 6'd0;
      if (minute_p0 != 6'd59) begin
        minute_nx = minute_p0 + 6'd1;
      end else begin
        minute_nx = 6'd0;
        if (hour_p0 != 5'd23) begin
          hour_nx = hour_p0 + 5'd1;
        end else begin
          hour_nx = 5'd0;
          if (day_p0 < cur_mlen) begin
            day_nx = day_p0 + 5'd1;
          end else begin
            day_nx = 5'd1;
            if (month_p0 < MONTH_DEC) begin
              month_nx = month_p0 + 4'd1;
            end else begin
              month_nx = MONTH_JAN;
              year_nx  = (year_p0 >= YMAX) ? '0 : (year_p0 + YEAR_W'(1));
            end
          end
        end
      end
    end
  end

  // Clamp a requested load into a legal time and date.
  always_comb begin
    set_sec    = sat_sixty(SET_TIME[SEC_LSB +: SEC_W]);
    set_minute = sat_sixty(SET_TIME[MIN_LSB +: MIN_W]);
    set_hour   = sat_hour(SET_TIME[HOUR_LSB +: HOUR_W]);
    set_year   = sat_year(SET_DATE[YEAR_LSB +: YEAR_W]);
    set_month  = sat_month(SET_DATE[MONTH_LSB +: MONTH_W]);
    set_day    = sat_day(SET_DATE[DAY_LSB +: DAY_W], month_len(set_month, set_year[1:0]));
  end

  // Stage p0: calendar state; a load wins over the second tick.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sec_p0    <= 6'd0;
      minute_p0 <= 6'd0;
      hour_p0   <= 5'd0;
      day_p0    <= 5'd1;
      month_p0  <= MONTH_JAN;
      year_p0   <= YINIT;
    end else if (SET_EN) begin
      sec_p0    <= set_sec;
      minute_p0 <= set_minute;
      hour_p0   <= set_hour;
      day_p0    <= set_day;
      month_p0  <= set_month;
      year_p0   <= set_year;
    end else if (tick) begin
      sec_p0    <= sec_nx;
      minute_p0 <= minute_nx;
      hour_p0   <= hour_nx;
      day_p0    <= day_nx;
      month_p0  <= month_nx;
      year_p0   <= year_nx;
    end
  end

  // Displayed hour field: plain 24h with pm=0, or {pm, 1..12}.
  always_comb begin
    disp_hour = {1'b0, hour_p0};
    if (H12 != 0) disp_hour = to_h12(hour_p0);
  end

  // Stage p1: second pulse marks a real increment, so a load suppresses it.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sec_tick_p1 <= 1'b0;
    end else begin
      sec_tick_p1 <= tick && !SET_EN;
    end
  end

  assign SEC_TICK = sec_tick_p1;

  // Stage p1: output snapshot, frozen while HOLD is high.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      OUT_TIME <= OUT_TIME_RST;
      OUT_DATE <= {YINIT, MONTH_JAN, 5'd1};
    end else if (!HOLD) begin
      OUT_TIME <= {disp_hour, minute_p0, sec_p0};
      OUT_DATE <= {year_p0, month_p0, day_p0};
    end
  end

`ifdef RTC_ALARM_EN
  logic alarm_hit_p1;

  // Stage p1: alarm fires when the second about to be entered matches.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      alarm_hit_p1 <= 1'b0;
    end else begin
      alarm_hit_p1 <= tick && ALARM_ARM && !SET_EN &&
                      ({hour_nx, minute_nx, sec_nx} == ALARM_TIME);
    end
  end

  assign ALARM_HIT = alarm_hit_p1;
`else
  logic unused_alarm;
  assign unused_alarm = ^{ALARM_TIME, ALARM_ARM};
  assign ALARM_HIT    = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Bench for rtc_calendar_core: a 24h and a 12h instance share stimulus and
// are compared every cycle against a seconds-of-day / date reference model.
module tb_rtc_calendar_core;

  localparam int T = 4;
`ifdef RTC_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        set_en;
  logic [16:0] set_time;
  logic [15:0] set_date;
  logic        hold;
  logic [16:0] alarm_time;
  logic        alarm_arm;

  logic        tick24, tick12, hit24, hit12;
  logic [17:0] time24, time12;
  logic [15:0] date24, date12;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_cnt, m_tod, m_day, m_mon, m_year;
  int o_tod, o_day, o_mon, o_year;
  bit o_tick, o_alarm;

  always #5 clk = ~clk;

  rtc_calendar_core #(.TICKS_PER_SEC(T), .H12(0)) dut24 (
    .CLK(clk), .RESETN(rstn), .SET_EN(set_en), .SET_TIME(set_time), .SET_DATE(set_date),
    .HOLD(hold), .ALARM_TIME(alarm_time), .ALARM_ARM(alarm_arm),
    .SEC_TICK(tick24), .OUT_TIME(time24), .OUT_DATE(date24), .ALARM_HIT(hit24));

  rtc_calendar_core #(.TICKS_PER_SEC(T), .H12(1)) dut12 (
    .CLK(clk), .RESETN(rstn), .SET_EN(set_en), .SET_TIME(set_time), .SET_DATE(set_date),
    .HOLD(hold), .ALARM_TIME(alarm_time), .ALARM_ARM(alarm_arm),
    .SEC_TICK(tick12), .OUT_TIME(time12), .OUT_DATE(date12), .ALARM_HIT(hit12));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mlen(int mo, int y);
    if (mo == 2) return (y % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic logic [16:0] tod_vec(int t);
    return {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction

  function automatic logic [17:0] exp_h12(int t);
    int   hr, h;
    logic pm;
    hr = t / 3600;
    pm = (hr >= 12);
    h  = hr % 12;
    if (h == 0) h = 12;
    return {pm, 5'(h), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction

  function automatic logic [15:0] date_vec(int y, int mo, int d);
    return {7'(y), 4'(mo), 5'(d)};
  endfunction

  // One clock edge of the reference model, using the inputs present now.
  task automatic model_edge();
    bit tick;
    int s, mi, h, y, mo, d;
    if (!rstn) begin
      m_cnt = 0; m_tod = 0; m_day = 1; m_mon = 1; m_year = 16;
      o_tod = 0; o_day = 1; o_mon = 1; o_year = 16;
      o_tick = 0; o_alarm = 0;
      return;
    end
    tick = (m_cnt == T - 1);
    if (!hold) begin
      o_tod = m_tod; o_day = m_day; o_mon = m_mon; o_year = m_year;
    end
    o_tick  = tick && !set_en;
    o_alarm = ALARM_ON && tick && !set_en && alarm_arm &&
              (tod_vec((m_tod + 1) % 86400) == alarm_time);
    if (set_en) begin
      s  = int'(set_time[5:0]);   if (s > 59) s = 0;
      mi = int'(set_time[11:6]);  if (mi > 59) mi = 0;
      h  = int'(set_time[16:12]); if (h > 23) h = 0;
      y  = int'(set_date[15:9]);  if (y > 99) y = 99;
      mo = int'(set_date[8:5]);   if (mo < 1 || mo > 12) mo = 1;
      d  = int'(set_date[4:0]);   if (d == 0) d = 1;
      if (d > mlen(mo, y)) d = mlen(mo, y);
      m_tod = h * 3600 + mi * 60 + s;
      m_year = y; m_mon = mo; m_day = d;
      m_cnt = 0;
    end else begin
      m_cnt = tick ? 0 : m_cnt + 1;
      if (tick) begin
        m_tod++;
        if (m_tod == 86400) begin
          m_tod = 0;
          m_day++;
          if (m_day > mlen(m_mon, m_year)) begin
            m_day = 1;
            m_mon++;
            if (m_mon > 12) begin
              m_mon  = 1;
              m_year = (m_year == 99) ? 0 : m_year + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("sec_tick24", 32'(tick24), 32'(o_tick));
    chk("sec_tick12", 32'(tick12), 32'(o_tick));
    chk("out_time24", 32'(time24), 32'({1'b0, tod_vec(o_tod)}));
    chk("out_time12", 32'(time12), 32'(exp_h12(o_tod)));
    chk("out_date24", 32'(date24), 32'(date_vec(o_year, o_mon, o_day)));
    chk("out_date12", 32'(date12), 32'(date_vec(o_year, o_mon, o_day)));
    chk("alarm24",    32'(hit24),  32'(o_alarm));
    chk("alarm12",    32'(hit12),  32'(o_alarm));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Load avoiding a cycle where the second would also tick.
  task automatic do_set(input int h, input int mi, input int s,
                        input int y, input int mo, input int d);
    if (m_cnt == T - 1) step();
    set_time = {5'(h), 6'(mi), 6'(s)};
    set_date = date_vec(y, mo, d);
    set_en   = 1'b1;
    step();
    set_en   = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    run(2);
    rstn = 1'b1;
  endtask

  int pulses, hits;
  int rh, rmi, rs, ry, rmo, rd;

  initial begin
    rstn = 1'b0; set_en = 1'b0; set_time = '0; set_date = '0;
    hold = 1'b0; alarm_time = '0; alarm_arm = 1'b0;

    // reset state
    run(2);
    chk("rst_time24", 32'(time24), 32'h0);
    chk("rst_time12", 32'(time12), 32'h0C000);
    chk("rst_date",   32'(date24), 32'(date_vec(16, 1, 1)));
    chk("rst_tick",   32'(tick24), 32'h0);
    rstn = 1'b1;

    // first second after reset
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tick24) pulses++;
    end
    chk("t1_pulses", 32'(pulses), 32'd1);
    chk("t1_sec",    32'(time24[5:0]), 32'd1);

    // year rollover
    do_set(23, 59, 59, 23, 12, 31);
    run(5);
    chk("t2_time", 32'(time24), 32'h0);
    chk("t2_date", 32'(date24), 32'(date_vec(24, 1, 1)));

    // leap and non-leap February
    do_set(23, 59, 59, 24, 2, 28);
    run(5);
    chk("t3_leap", 32'(date24), 32'(date_vec(24, 2, 29)));
    do_set(23, 59, 59, 23, 2, 28);
    run(5);
    chk("t3_noleap", 32'(date24), 32'(date_vec(23, 3, 1)));

    // sanitising
    do_set(10, 0, 0, 20, 4, 31);
    run(1);
    chk("t4_day_clip", 32'(date24), 32'(date_vec(20, 4, 30)));
    do_set(25, 0, 0, 20, 4, 1);
    run(1);
    chk("t4_hour_clip", 32'(time24[16:12]), 32'd0);

    // 12h mapping
    do_set(0, 0, 0, 20, 5, 5);
    run(1);
    chk("t5_h0",  32'(time12[17:12]), 32'({1'b0, 5'd12}));
    do_set(12, 0, 0, 20, 5, 5);
    run(1);
    chk("t5_h12", 32'(time12[17:12]), 32'({1'b1, 5'd12}));
    do_set(13, 0, 0, 20, 5, 5);
    run(1);
    chk("t5_h13", 32'(time12[17:12]), 32'({1'b1, 5'd1}));

    // hold across a tick, then release
    do_set(5, 6, 7, 20, 5, 5);
    run(1);
    hold = 1'b1;
    run(5);
    chk("t5_hold", 32'(time24), 32'({1'b0, 5'd5, 6'd6, 6'd7}));
    hold = 1'b0;
    run(1);
    chk("t5_release", 32'(time24[5:0]), 32'd8);

    // alarm armed, then disarmed
    alarm_time = {5'd0, 6'd0, 6'd2};
    alarm_arm  = 1'b1;
    do_reset();
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (hit24) hits++;
    end
    chk("t6_armed", 32'(hits), ALARM_ON ? 32'd1 : 32'd0);
    alarm_arm = 1'b0;
    do_reset();
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (hit24) hits++;
    end
    chk("t6_disarmed", 32'(hits), 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      hold   = ($urandom % 8 == 0);
      rstn   = ($urandom % 300 != 0);
      set_en = 1'b0;
      if (m_cnt != T - 1 && $urandom % 30 == 0) begin
        rh  = ($urandom % 2 == 0) ? 23 : int'($urandom % 32);
        rmi = ($urandom % 2 == 0) ? 59 : int'($urandom % 64);
        rs  = ($urandom % 2 == 0) ? int'($urandom_range(57, 59)) : int'($urandom % 64);
        case ($urandom % 4)
          0: ry = 99;
          1: ry = 98;
          2: ry = 127;
          default: ry = int'($urandom % 128);
        endcase
        rmo = ($urandom % 3 == 0) ? int'($urandom_range(1, 2)) + 10 * int'($urandom % 2)
                                  : int'($urandom % 16);
        rd  = ($urandom % 2 == 0) ? int'($urandom_range(27, 31)) : int'($urandom % 32);
        set_time = {5'(rh), 6'(rmi), 6'(rs)};
        set_date = date_vec(ry, rmo, rd);
        set_en   = 1'b1;
      end
      if ($urandom % 25 == 0) begin
        alarm_time = tod_vec((m_tod + int'($urandom_range(1, 3))) % 86400);
        alarm_arm  = ($urandom % 4 != 0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
